// File: rtl/sprite_pkg.sv
// Shared sprite-pipeline definitions: line geometry defaults, line-buffer
// controller state encoding and counter sizing helper.
package sprite_pkg;

  localparam int SPR_LINE_WIDTH   = 640;
  localparam int SPR_ERASE_CYCLES = SPR_LINE_WIDTH / 4;
  localparam int SPR_IDX_W        = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ERASE  = 2'd2,
    S_WAIT   = 2'd3
  } linebuf_state_e;

  // Bits needed to hold a down-counter that starts at 'cycles'.
  function automatic int erase_cnt_width(input int cycles);
    if (cycles < 1) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sprite_linebuf_ctrl.sv
// Ping-pong sprite line-buffer controller: swaps render/display halves on
// line_start, walks the composer read index and sequences the erase sweep.
module sprite_linebuf_ctrl
  import sprite_pkg::*;
#(
  parameter int LINE_WIDTH   = SPR_LINE_WIDTH,
  parameter int ERASE_CYCLES = LINE_WIDTH / 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line_start,
  input  logic                 render_done,
  input  logic                 composer_pix_en,
  output logic                 active_render_buffer,
  output logic                 renderer_start,
  output logic [SPR_IDX_W-1:0] composer_rd_idx,
  output logic                 composer_rd_valid,
  output logic                 composer_erase_start,
  output logic                 render_overrun,
  output logic                 busy
);

  localparam int                   CNT_W      = erase_cnt_width(ERASE_CYCLES);
  localparam logic [SPR_IDX_W-1:0] LAST_IDX   = SPR_IDX_W'(LINE_WIDTH - 1);
  localparam logic [CNT_W-1:0]     ERASE_LOAD = CNT_W'(ERASE_CYCLES);

  linebuf_state_e       r_state;
  logic                 r_active_buf;
  logic [SPR_IDX_W-1:0] r_rd_idx;
  logic                 r_rd_valid;
  logic                 r_renderer_start;
  logic                 r_erase_start;
  logic                 r_overrun;
  logic                 r_busy;
  logic                 r_done_seen;
  logic                 r_swap_pending;
  logic [CNT_W-1:0]     r_erase_cnt;

  logic w_done_seen;
  logic w_erase_done;
  logic w_last_pix;
  logic w_start_erase;
  logic w_swap;

  // A render_done arriving in the swap cycle still belongs to the outgoing line.
  assign w_done_seen   = r_done_seen | render_done;
  assign w_erase_done  = (r_state == S_ERASE) && (r_erase_cnt == '0);
  assign w_last_pix    = (r_state == S_ACTIVE) && composer_pix_en && (r_rd_idx == LAST_IDX);
  assign w_start_erase = (r_state == S_ACTIVE) && (line_start || w_last_pix);
  assign w_swap        = (((r_state == S_IDLE) || (r_state == S_WAIT)) && line_start)
                       || (w_erase_done && (r_swap_pending || line_start));

  // NOTE: every register below uses <= so all updates see pre-edge values;
  // blocking assignments here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_active_buf     <= 1'b0;
      r_rd_idx         <= '0;
      r_rd_valid       <= 1'b0;
      r_renderer_start <= 1'b0;
      r_erase_start    <= 1'b0;
      r_overrun        <= 1'b0;
      r_busy           <= 1'b0;
      r_done_seen      <= 1'b0;
      r_swap_pending   <= 1'b0;
      r_erase_cnt      <= '0;
    end else begin
      r_renderer_start <= 1'b0;
      r_erase_start    <= 1'b0;
      r_overrun        <= 1'b0;
      // The dpram returns data one cycle after an accepted read request.
      r_rd_valid       <= (r_state == S_ACTIVE) && composer_pix_en;

      if (w_swap) begin
        r_active_buf     <= ~r_active_buf;
        r_rd_idx         <= '0;
        r_done_seen      <= 1'b0;
        r_swap_pending   <= 1'b0;
        r_renderer_start <= 1'b1;
        // r_busy is low only before the first swap, which is never an overrun.
        r_overrun        <= r_busy && !w_done_seen;
        r_busy           <= 1'b1;
        r_state          <= S_ACTIVE;
      end else begin
        if (render_done) r_done_seen <= 1'b1;

        case (r_state)
          S_ACTIVE: begin
            if (w_start_erase) begin
              r_erase_start  <= 1'b1;
              r_erase_cnt    <= ERASE_LOAD;
              r_swap_pending <= line_start;
              r_state        <= S_ERASE;
            end else if (composer_pix_en) begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
          S_ERASE: begin
            if (w_erase_done) begin
              r_state <= S_WAIT;
            end else begin
              r_erase_cnt <= r_erase_cnt - 1'b1;
              if (line_start) r_swap_pending <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign active_render_buffer = r_active_buf;
  assign renderer_start       = r_renderer_start;
  assign composer_rd_idx      = r_rd_idx;
  assign composer_rd_valid    = r_rd_valid;
  assign composer_erase_start = r_erase_start;
  assign render_overrun       = r_overrun;
  assign busy                 = r_busy;

endmodule

// File: tb/tb_sprite_linebuf_ctrl.sv
// Directed + randomized bench for sprite_linebuf_ctrl against a line-level
// reference model that tracks erase windows by absolute cycle deadlines.
module tb_sprite_linebuf_ctrl;

  localparam int LW = 640;
  localparam int EC = LW / 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       line_start = 1'b0;
  logic       render_done = 1'b0;
  logic       composer_pix_en = 1'b0;
  logic       active_render_buffer;
  logic       renderer_start;
  logic [9:0] composer_rd_idx;
  logic       composer_rd_valid;
  logic       composer_erase_start;
  logic       render_overrun;
  logic       busy;

  sprite_linebuf_ctrl #(.LINE_WIDTH(LW), .ERASE_CYCLES(EC)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .line_start           (line_start),
    .render_done          (render_done),
    .composer_pix_en      (composer_pix_en),
    .active_render_buffer (active_render_buffer),
    .renderer_start       (renderer_start),
    .composer_rd_idx      (composer_rd_idx),
    .composer_rd_valid    (composer_rd_valid),
    .composer_erase_start (composer_erase_start),
    .render_overrun       (render_overrun),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int es_cyc = 0;

  // Reference model: what the line is doing, not how the RTL counts it.
  localparam int P_IDLE = 0, P_READ = 1, P_ERASE = 2, P_WAIT = 3;
  int m_phase, m_idx, m_erase_end;
  bit m_buf, m_seen, m_pend, m_started;
  bit e_rs, e_es, e_ov, e_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_idx = 0; m_erase_end = -1;
    m_buf = 0; m_seen = 0; m_pend = 0; m_started = 0;
    e_rs = 0; e_es = 0; e_ov = 0; e_valid = 0;
  endtask

  // Predict outputs for the cycle after 'cyc' given this cycle's inputs.
  task automatic model_step(input bit ls, input bit rd, input bit pe);
    bit erase_over, swap;
    e_rs = 0; e_es = 0; e_ov = 0;
    e_valid    = (m_phase == P_READ) && pe;
    erase_over = (m_phase == P_ERASE) && (cyc == m_erase_end);
    swap = ((m_phase == P_IDLE || m_phase == P_WAIT) && ls) || (erase_over && (m_pend || ls));
    if (swap) begin
      e_ov = m_started && !(m_seen || rd);
      e_rs = 1; m_buf = !m_buf; m_idx = 0; m_seen = 0; m_pend = 0;
      m_started = 1; m_phase = P_READ;
    end else begin
      if (rd) m_seen = 1;
      if (m_phase == P_READ) begin
        if (ls || (pe && m_idx == LW - 1)) begin
          // Erase window: erase_start seen at cyc+1, lasts EC+1 cycles.
          e_es = 1; m_phase = P_ERASE; m_erase_end = cyc + 1 + EC; m_pend = ls;
        end else if (pe) begin
          m_idx++;
        end
      end else if (m_phase == P_ERASE) begin
        if (erase_over) m_phase = P_WAIT;
        else if (ls) m_pend = 1;
      end
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".buf"},   32'(active_render_buffer), 32'(m_buf));
    check({pfx, ".rs"},    32'(renderer_start),       32'(e_rs));
    check({pfx, ".idx"},   32'(composer_rd_idx),      32'(m_idx));
    check({pfx, ".valid"}, 32'(composer_rd_valid),    32'(e_valid));
    check({pfx, ".es"},    32'(composer_erase_start), 32'(e_es));
    check({pfx, ".ovr"},   32'(render_overrun),       32'(e_ov));
    check({pfx, ".busy"},  32'(busy),                 32'(m_started));
  endtask

  task automatic step(input bit ls, input bit rd, input bit pe);
    line_start = ls; render_done = rd; composer_pix_en = pe;
    model_step(ls, rd, pe);
    @(posedge clk);
    #1;
    cyc++;
    check_all("model");
    if (composer_erase_start) es_cyc = cyc;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".buf"},   32'(active_render_buffer), 32'd0);
    check({tag, ".rs"},    32'(renderer_start),       32'd0);
    check({tag, ".idx"},   32'(composer_rd_idx),      32'd0);
    check({tag, ".valid"}, 32'(composer_rd_valid),    32'd0);
    check({tag, ".es"},    32'(composer_erase_start), 32'd0);
    check({tag, ".ovr"},   32'(render_overrun),       32'd0);
    check({tag, ".busy"},  32'(busy),                 32'd0);
  endtask

  task automatic finish_line(input int idle_cycles);
    for (int i = 0; i < LW; i++) step(0, 0, 1);
    for (int i = 0; i < idle_cycles; i++) step(0, 0, 0);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full line: buffer 0->1->0, erase_start right after the 640th pixel.
    step(1, 0, 0);
    check("l1.buf", 32'(active_render_buffer), 32'd1);
    check("l1.rs",  32'(renderer_start), 32'd1);
    check("l1.valid_after_swap", 32'(composer_rd_valid), 32'd0);
    step(0, 1, 0);
    for (int i = 0; i < LW; i++) begin
      step(0, 0, 1);
      check("l1.valid_each_pix", 32'(composer_rd_valid), 32'd1);
    end
    check("l1.es_after_640", 32'(composer_erase_start), 32'd1);
    check("l1.idx_hold", 32'(composer_rd_idx), 32'd639);
    for (int i = 0; i < 200; i++) step(0, 0, 0);
    step(1, 0, 0);
    check("l2.buf", 32'(active_render_buffer), 32'd0);
    check("l2.rs",  32'(renderer_start), 32'd1);
    check("l2.ovr", 32'(render_overrun), 32'd0);

    // Early line_start: erase right away, pending swap 161 cycles later.
    step(0, 1, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 1);
    step(1, 0, 0);
    check("short.es", 32'(composer_erase_start), 32'd1);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0);
      if (renderer_start) break;
    end
    check("short.erase_to_swap", 32'(cyc - es_cyc), 32'd161);
    check("short.idx0", 32'(composer_rd_idx), 32'd0);

    // Line without render_done overruns; next one with it does not.
    finish_line(170);
    step(1, 0, 0);
    check("ovr.pulse", 32'(render_overrun), 32'd1);
    check("ovr.rs",    32'(renderer_start), 32'd1);
    step(0, 1, 0);
    finish_line(170);
    step(1, 0, 0);
    check("ovr.none", 32'(render_overrun), 32'd0);

    // render_done coincident with line_start in the wait state.
    finish_line(170);
    step(1, 1, 0);
    check("same.rs",  32'(renderer_start), 32'd1);
    check("same.ovr", 32'(render_overrun), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 399) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1);

    // Reset 50 cycles into an erase sweep.
    for (int i = 0; i < 400 && m_phase != P_READ; i++)
      step(m_phase == P_IDLE || m_phase == P_WAIT, 0, 0);
    step(1, 0, 0);
    check("rst.es", 32'(composer_erase_start), 32'd1);
    for (int i = 0; i < 50; i++) step(0, 0, 0);
    line_start = 0; render_done = 0; composer_pix_en = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 200; i++) step(0, 0, 0);
    step(1, 0, 0);
    check("postrst.buf", 32'(active_render_buffer), 32'd1);
    check("postrst.rs",  32'(renderer_start), 32'd1);
    check("postrst.ovr", 32'(render_overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sprite_linebuf_ctrl.md
SPRITE_LINEBUF_CTRL -- requirements
Module: sprite_linebuf_ctrl

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 640: composer pixels read per line, range 4..1024, multiple of 4.
REQ-002 SHALL have parameter ERASE_CYCLES, default LINE_WIDTH/4: cycles one erase sweep occupies in sprite_line_buffer.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 line_start  input  1  one-cycle pulse at start of each display line.
REQ-006 render_done  input  1  one-cycle pulse: renderer finished current line.
REQ-007 composer_pix_en  input  1  composer requests next sprite pixel this cycle.
REQ-008 active_render_buffer  output  1  buffer-select to sprite_line_buffer.
REQ-009 renderer_start  output  1  one-cycle pulse: renderer may begin a new line.
REQ-010 composer_rd_idx  output  10  composer read index to sprite_line_buffer.
REQ-011 composer_rd_valid  output  1  composer_rd_data is valid this cycle.
REQ-012 composer_erase_start  output  1  one-cycle pulse to sprite_line_buffer erase logic.
REQ-013 render_overrun  output  1  one-cycle pulse: swap occurred without render_done.
REQ-014 busy  output  1  high in every state except S_IDLE.

Function
REQ-015 SHALL implement states S_IDLE, S_ACTIVE, S_ERASE, S_WAIT.
REQ-016 S_IDLE: line_start -> swap, enter S_ACTIVE.
REQ-017 Swap SHALL be one cycle: invert active_render_buffer, set composer_rd_idx=0, clear render_done_seen, pulse renderer_start.
REQ-018 S_ACTIVE: each composer_pix_en with composer_rd_idx < LINE_WIDTH-1 increments composer_rd_idx by 1.
REQ-019 composer_pix_en at composer_rd_idx == LINE_WIDTH-1 SHALL hold index, pulse composer_erase_start next cycle, and enter S_ERASE.
REQ-020 composer_rd_valid SHALL equal composer_pix_en delayed one cycle (dpram read latency); it SHALL be 0 in the cycle after a swap.
REQ-021 composer_pix_en outside S_ACTIVE SHALL be ignored (idx unchanged, no valid).
REQ-022 S_ERASE SHALL count ERASE_CYCLES+1 cycles from the erase_start pulse, then enter S_WAIT.
REQ-023 S_WAIT: line_start -> swap, enter S_ACTIVE.
REQ-024 line_start in S_ACTIVE (composer short of LINE_WIDTH): pulse composer_erase_start next cycle, enter S_ERASE, set swap_pending.
REQ-025 line_start in S_ERASE: set swap_pending.
REQ-026 On S_ERASE completion with swap_pending: perform swap in that same cycle, clear swap_pending, enter S_ACTIVE instead of S_WAIT.
REQ-027 render_done in any state after a swap SHALL set render_done_seen; a second render_done before next swap is ignored.
REQ-028 At every swap with render_done_seen==0 (except the first swap from S_IDLE), render_overrun SHALL pulse in the swap cycle; swap still proceeds.
REQ-029 render_done and line_start in the same cycle: render_done counts toward the outgoing line (no overrun).
REQ-030 active_render_buffer SHALL change only in swap cycles; never during S_ERASE.
REQ-031 composer_erase_start SHALL never issue while a previous erase count is nonzero.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst_n low SHALL asynchronously force: state S_IDLE, active_render_buffer=0, composer_rd_idx=0, all pulses/valid=0, busy=0, counters, swap_pending and render_done_seen cleared.
REQ-034 Reset mid-erase SHALL abandon the sweep; no erase_start reissued until next S_ACTIVE completion.
REQ-035 First line_start after rst_n release SHALL be honoured in S_IDLE per REQ-016.

Structure
REQ-036 State encodings and LINE_WIDTH/ERASE_CYCLES defaults SHALL live in shared package sprite_pkg, also used by the sprite renderer and composer.
REQ-037 Erase-cycle counter SHALL be sized from ERASE_CYCLES (8 bits at default).
REQ-038 No sub-module; controller is a flat FSM plus counters, instantiated beside sprite_line_buffer in the sprite top.

Verification
REQ-039 Reset, line_start, render_done, 640 pix_en, wait, line_start -> active_render_buffer 0->1->0, erase_start 1 cycle after 640th pix_en, renderer_start at both swaps, no overrun.
REQ-040 pix_en every cycle from idx 0 -> composer_rd_valid 1 cycle after each pix_en; idx stops at 639.
REQ-041 line_start after 300 pix_en -> erase_start next cycle; swap exactly 161 cycles later; idx 0.
REQ-042 Second line without render_done -> render_overrun pulse coincident with swap; third line with render_done -> none.
REQ-043 line_start and render_done same cycle in S_WAIT -> swap, render_overrun 0.
REQ-044 rst_n low 50 cycles into erase -> all outputs at reset values immediately; next line_start swaps to buffer 1, no stray erase_start.
